proc_ctrl: RTL and testbench



---
 rtl/proc_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_proc_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_ctrl.sv
// proc_ctrl: multi-cycle control FSM for the 16-bit processor datapath.
//
// Sequences fetch (T0-T2) and execute (T3-T5) and decodes state plus IR into
// every datapath enable. R7 is the program counter.
//
// Ports:
//   clk      in   system clock, rising edge
//   resetn   in   asynchronous active-low reset (forces T0, all outputs 0)
//   run      in   start/continue execution, sampled in T0 only
//   ir[15:0] in   IR contents: op=[15:13] imm=[12] rx=[11:9] ry=[2:0]
//   z        in   ALU zero flag (registered with G)
//   sel      out  bus-mux select (0-7 Rn, SEL_IMM, SEL_DIN, SEL_G)
//   r_in     out  one-hot register write enables R0-R7
//   a_in, g_in, ir_in, addr_in, dout_in  out  datapath load enables
//   alu_op   out  00 add, 01 sub, 10 and
//   w_d      out  memory write strobe
//   pc_incr  out  increment R7
//   done     out  pulse on the last cycle of each instruction
//
// Build option: define PROC_CTRL_BRANCH_EN to make op 111 a conditional
// relative branch; otherwise op 111 is a single-cycle-execute nop.
module proc_ctrl #(
  parameter logic [3:0] SEL_IMM = 4'd8,
  parameter logic [3:0] SEL_DIN = 4'd9,
  parameter logic [3:0] SEL_G   = 4'd10
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        run,
  input  logic [15:0] ir,
  input  logic        z,
  output logic [3:0]  sel,
  output logic [7:0]  r_in,
  output logic        a_in,
  output logic        g_in,
  output logic [1:0]  alu_op,
  output logic        ir_in,
  output logic        addr_in,
  output logic        dout_in,
  output logic        w_d,
  output logic        pc_incr,
  output logic        done
);

  typedef enum logic [2:0] {StT0, StT1, StT2, StT3, StT4, StT5} state_e;

  localparam logic [2:0] OpMv  = 3'b000;
  localparam logic [2:0] OpMvt = 3'b001;
  localparam logic [2:0] OpAdd = 3'b010;
  localparam logic [2:0] OpSub = 3'b011;
  localparam logic [2:0] OpLd  = 3'b100;
  localparam logic [2:0] OpSt  = 3'b101;
  localparam logic [2:0] OpAnd = 3'b110;
  localparam logic [2:0] OpBr  = 3'b111;

  state_e r_state, w_state_d;

  logic [2:0] w_op, w_rx, w_ry;
  logic       w_imm;
  logic [7:0] w_rx_onehot;
  logic [3:0] w_sel_op2;
  logic [1:0] w_alu_code;
  logic       w_taken;
  logic       w_unused;

  assign w_op        = ir[15:13];
  assign w_imm       = ir[12];
  assign w_rx        = ir[11:9];
  assign w_ry        = ir[2:0];
  assign w_rx_onehot = 8'b1 << w_rx;
  assign w_sel_op2   = w_imm ? SEL_IMM : {1'b0, w_ry};
  assign w_alu_code  = (w_op == OpSub) ? 2'b01 : (w_op == OpAnd) ? 2'b10 : 2'b00;
  // Branch condition lives in the rx field.
  assign w_taken     = (w_rx == 3'b000) | ((w_rx == 3'b001) & z) | ((w_rx == 3'b010) & ~z);
  // Middle IR bits are datapath-only; z/w_taken are unused without branches.
  assign w_unused    = ^{ir[8:3], w_taken};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= StT0;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    sel       = 4'd0;
    r_in      = 8'h00;
    a_in      = 1'b0;
    g_in      = 1'b0;
    alu_op    = 2'b00;
    ir_in     = 1'b0;
    addr_in   = 1'b0;
    dout_in   = 1'b0;
    w_d       = 1'b0;
    pc_incr   = 1'b0;
    done      = 1'b0;

    case (r_state)
      StT0: begin
        if (run) begin
          sel       = 4'd7;
          addr_in   = 1'b1;
          pc_incr   = 1'b1;
          w_state_d = StT1;
        end
      end
      StT1: w_state_d = StT2;  // memory latency
      StT2: begin
        ir_in     = 1'b1;
        w_state_d = StT3;
      end
      StT3: begin
        case (w_op)
          OpMv: begin
            sel  = w_sel_op2;
            r_in = w_rx_onehot;
            done = 1'b1;
          end
          OpMvt: begin
            if (w_imm) begin
              sel  = SEL_IMM;
              r_in = w_rx_onehot;
            end
            done = 1'b1;
          end
          OpAdd, OpSub, OpAnd: begin
            sel       = {1'b0, w_rx};
            a_in      = 1'b1;
            w_state_d = StT4;
          end
          OpLd, OpSt: begin
            sel       = {1'b0, w_ry};
            addr_in   = 1'b1;
            w_state_d = StT4;
          end
          OpBr: begin
`ifdef PROC_CTRL_BRANCH_EN
            sel       = 4'd7;
            a_in      = 1'b1;
            w_state_d = StT4;
`else
            done      = 1'b1;
`endif
          end
          default: done = 1'b1;
        endcase
      end
      StT4: begin
        case (w_op)
          OpAdd, OpSub, OpAnd: begin
            sel       = w_sel_op2;
            g_in      = 1'b1;
            alu_op    = w_alu_code;
            w_state_d = StT5;
          end
          OpLd: w_state_d = StT5;
          OpSt: begin
            sel     = {1'b0, w_rx};
            dout_in = 1'b1;
            w_d     = 1'b1;
            done    = 1'b1;
          end
`ifdef PROC_CTRL_BRANCH_EN
          OpBr: begin
            sel    = SEL_IMM;
            g_in   = 1'b1;
            alu_op = 2'b00;
            if (w_taken) begin
              w_state_d = StT5;
            end else begin
              done = 1'b1;
            end
          end
`endif
          default: w_state_d = StT0;
        endcase
      end
      StT5: begin
        case (w_op)
          OpAdd, OpSub, OpAnd: begin
            sel  = SEL_G;
            r_in = w_rx_onehot;
            done = 1'b1;
          end
          OpLd: begin
            sel  = SEL_DIN;
            r_in = w_rx_onehot;
            done = 1'b1;
          end
`ifdef PROC_CTRL_BRANCH_EN
          OpBr: begin
            sel  = SEL_G;
            r_in = 8'h80;
            done = 1'b1;
          end
`endif
          default: w_state_d = StT0;
        endcase
      end
      default: w_state_d = StT0;
    endcase

    if (done) begin
      w_state_d = StT0;
    end

    // Outputs are forced quiet for the whole time reset is held, not just at
    // the edge, so no enable can fire while the state register is held.
    if (!resetn) begin
      sel     = 4'd0;
      r_in    = 8'h00;
      a_in    = 1'b0;
      g_in    = 1'b0;
      alu_op  = 2'b00;
      ir_in   = 1'b0;
      addr_in = 1'b0;
      dout_in = 1'b0;
      w_d     = 1'b0;
      pc_incr = 1'b0;
      done    = 1'b0;
    end
  end

endmodule

// File: tb/tb_proc_ctrl.sv
// Directed self-checking bench for proc_ctrl. All outputs are packed into one
// vector; expected vectors are built from hand-decoded instruction fields.
module tb_proc_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        run = 1'b0;
  logic [15:0] ir = 16'h0000;
  logic        z = 1'b0;
  logic [3:0]  sel;
  logic [7:0]  r_in;
  logic        a_in, g_in, ir_in, addr_in, dout_in, w_d, pc_incr, done;
  logic [1:0]  alu_op;

  int tests = 0;
  int failed = 0;

  proc_ctrl dut (
    .clk     (clk),
    .resetn  (resetn),
    .run     (run),
    .ir      (ir),
    .z       (z),
    .sel     (sel),
    .r_in    (r_in),
    .a_in    (a_in),
    .g_in    (g_in),
    .alu_op  (alu_op),
    .ir_in   (ir_in),
    .addr_in (addr_in),
    .dout_in (dout_in),
    .w_d     (w_d),
    .pc_incr (pc_incr),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Packed view: sel[21:18] r_in[17:10] a[9] g[8] alu[7:6] ir[5] addr[4] dout[3] wd[2] pc[1] done[0]
  logic [21:0] obs;
  assign obs = {sel, r_in, a_in, g_in, alu_op, ir_in, addr_in, dout_in, w_d, pc_incr, done};

  localparam logic [21:0] A_IN  = 22'h000200;
  localparam logic [21:0] G_IN  = 22'h000100;
  localparam logic [21:0] IR_IN = 22'h000020;
  localparam logic [21:0] ADDR  = 22'h000010;
  localparam logic [21:0] DOUT  = 22'h000008;
  localparam logic [21:0] WD    = 22'h000004;
  localparam logic [21:0] PC    = 22'h000002;
  localparam logic [21:0] DONE  = 22'h000001;

  function automatic logic [21:0] sv(input logic [3:0] s);
    return {s, 18'b0};
  endfunction
  function automatic logic [21:0] rv(input logic [7:0] r);
    return {4'b0, r, 10'b0};
  endfunction
  function automatic logic [21:0] av(input logic [1:0] a);
    return {14'b0, a, 6'b0};
  endfunction

  // Advance one clock; drive run just after the edge, leave time to settle.
  task automatic step(input logic run_v);
    @(posedge clk);
    #1 run = run_v;
    #1;
  endtask

  task automatic test_reset();
    logic [21:0] zero;
    zero = '0;
    run = 1'b1;
    #2 resetn = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (obs !== zero) begin
        failed++;
        $display("FAIL reset_held[%0d]: got %h expected %h", i, obs, zero);
      end
      @(posedge clk);
      #1;
    end
    resetn = 1'b1;
    run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0);
      tests++;
      if (obs !== zero) begin
        failed++;
        $display("FAIL reset_idle[%0d]: got %h expected %h", i, obs, zero);
      end
    end
  endtask

  task automatic test_mv();
    logic [21:0] e [5];
    e[0] = sv(4'd7) | ADDR | PC;
    e[1] = '0;
    e[2] = IR_IN;
    e[3] = sv(4'd8) | rv(8'h02) | DONE;
    e[4] = '0;
    ir = 16'h1205;
    run = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step(1'b0);
      tests++;
      if (obs !== e[i]) begin
        failed++;
        $display("FAIL mv[%0d]: got %h expected %h", i, obs, e[i]);
      end
    end
  endtask

  task automatic test_mvt();
    logic [21:0] e [4];
    e[0] = sv(4'd7) | ADDR | PC;
    e[1] = '0;
    e[2] = IR_IN;
    e[3] = DONE;
    ir = 16'h2A00;  // mvt imm=0: nop
    run = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step(1'b0);
      tests++;
      if (obs !== e[i]) begin
        failed++;
        $display("FAIL mvt_nop[%0d]: got %h expected %h", i, obs, e[i]);
      end
    end
    step(1'b0);
    e[3] = sv(4'd8) | rv(8'h04) | DONE;
    ir = 16'h3400;  // mvt r2
    run = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step(1'b0);
      tests++;
      if (obs !== e[i]) begin
        failed++;
        $display("FAIL mvt[%0d]: got %h expected %h", i, obs, e[i]);
      end
    end
    step(1'b0);
  endtask

  // add r2,r3 / sub r7,#imm / and r3,r6 : 6 cycles, back to idle on 7th.
  task automatic test_alu();
    logic [15:0] irs [3];
    logic [21:0] e [3][7];
    irs[0] = 16'h4403;
    irs[1] = 16'h7E00;
    irs[2] = 16'hC606;
    for (int k = 0; k < 3; k++) begin
      e[k][0] = sv(4'd7) | ADDR | PC;
      e[k][1] = '0;
      e[k][2] = IR_IN;
      e[k][6] = '0;
    end
    e[0][3] = sv(4'd2) | A_IN;
    e[0][4] = sv(4'd3) | G_IN | av(2'b00);
    e[0][5] = sv(4'd10) | rv(8'h04) | DONE;
    e[1][3] = sv(4'd7) | A_IN;
    e[1][4] = sv(4'd8) | G_IN | av(2'b01);
    e[1][5] = sv(4'd10) | rv(8'h80) | DONE;
    e[2][3] = sv(4'd3) | A_IN;
    e[2][4] = sv(4'd6) | G_IN | av(2'b10);
    e[2][5] = sv(4'd10) | rv(8'h08) | DONE;
    for (int k = 0; k < 3; k++) begin
      ir = irs[k];
      run = 1'b1;
      #1;
      for (int i = 0; i < 7; i++) begin
        if (i > 0) step(1'b0);
        tests++;
        if (obs !== e[k][i]) begin
          failed++;
          $display("FAIL alu%0d[%0d]: got %h expected %h", k, i, obs, e[k][i]);
        end
      end
    end
  endtask

  task automatic test_st();
    logic [21:0] e [6];
    e[0] = sv(4'd7) | ADDR | PC;
    e[1] = '0;
    e[2] = IR_IN;
    e[3] = sv(4'd1) | ADDR;
    e[4] = sv(4'd0) | DOUT | WD | DONE;
    e[5] = '0;
    ir = 16'hA001;
    run = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step(1'b0);
      tests++;
      if (obs !== e[i]) begin
        failed++;
        $display("FAIL st[%0d]: got %h expected %h", i, obs, e[i]);
      end
    end
  endtask

  task automatic test_ld();
    logic [21:0] e [7];
    e[0] = sv(4'd7) | ADDR | PC;
    e[1] = '0;
    e[2] = IR_IN;
    e[3] = sv(4'd5) | ADDR;
    e[4] = '0;
    e[5] = sv(4'd9) | rv(8'h10) | DONE;
    e[6] = '0;
    ir = 16'h8805;
    run = 1'b1;
    #1;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) step(1'b0);
      tests++;
      if (obs !== e[i]) begin
        failed++;
        $display("FAIL ld[%0d]: got %h expected %h", i, obs, e[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [21:0] zero;
    logic [21:0] fetch;
    zero  = '0;
    fetch = sv(4'd7) | ADDR | PC;
    ir = 16'h8805;
    run = 1'b1;
    #1;
    for (int i = 1; i < 5; i++) step(1'b1);  // now in T4 of ld
    resetn = 1'b0;
    #1;
    tests++;
    if (obs !== zero) begin
      failed++;
      $display("FAIL reset_mid_immediate: got %h expected %h", obs, zero);
    end
    @(posedge clk);
    #1;
    tests++;
    if (obs !== zero) begin
      failed++;
      $display("FAIL reset_mid_held: got %h expected %h", obs, zero);
    end
    resetn = 1'b1;
    run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0);
      tests++;
      if (obs !== zero) begin
        failed++;
        $display("FAIL reset_mid_after[%0d]: got %h expected %h", i, obs, zero);
      end
    end
    run = 1'b1;
    #1;
    tests++;
    if (obs !== fetch) begin
      failed++;
      $display("FAIL reset_mid_refetch: got %h expected %h", obs, fetch);
    end
    for (int i = 0; i < 6; i++) step(1'b0);  // let the restarted ld finish
  endtask

  task automatic test_branch();
    logic [21:0] e [7];
    e[0] = sv(4'd7) | ADDR | PC;
    e[1] = '0;
    e[2] = IR_IN;
`ifdef PROC_CTRL_BRANCH_EN
    // beq -2, z=0: not taken, done in T4.
    e[3] = sv(4'd7) | A_IN;
    e[4] = sv(4'd8) | G_IN | DONE;
    e[5] = '0;
    ir = 16'hF3FE;
    z = 1'b0;
    run = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step(1'b0);
      tests++;
      if (obs !== e[i]) begin
        failed++;
        $display("FAIL beq_nt[%0d]: got %h expected %h", i, obs, e[i]);
      end
    end
    // beq -2, z=1: taken, writes R7 via G in T5.
    e[4] = sv(4'd8) | G_IN;
    e[5] = sv(4'd10) | rv(8'h80) | DONE;
    e[6] = '0;
    z = 1'b1;
    run = 1'b1;
    #1;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) step(1'b0);
      tests++;
      if (obs !== e[i]) begin
        failed++;
        $display("FAIL beq_t[%0d]: got %h expected %h", i, obs, e[i]);
      end
    end
    // cond 011 is never taken regardless of z.
    e[4] = sv(4'd8) | G_IN | DONE;
    e[5] = '0;
    ir = 16'hE600;
    run = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step(1'b0);
      tests++;
      if (obs !== e[i]) begin
        failed++;
        $display("FAIL bnever[%0d]: got %h expected %h", i, obs, e[i]);
      end
    end
`else
    // op 111 without branch support: nop, done in T3.
    e[3] = DONE;
    e[4] = '0;
    ir = 16'hF3FE;
    z = 1'b1;
    run = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step(1'b0);
      tests++;
      if (obs !== e[i]) begin
        failed++;
        $display("FAIL op7_nop[%0d]: got %h expected %h", i, obs, e[i]);
      end
    end
`endif
    z = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mv();
    test_mvt();
    test_alu();
    test_st();
    test_ld();
    test_reset_mid();
    test_branch();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
